div_rem: RTL and testbench
==========================

# div_rem

Sequential unsigned divider: the inverse of the multiply-accumulate path. Given a 2·WIDTH-bit value n and a WIDTH-bit divisor d, it recovers quotient q and remainder r such that n = q·d + r with r < d. It uses restoring division, one quotient bit per clock. It sits after the multiply-accumulate stage, so a result a·b+c divided by b returns a and c whenever c < b.

## Interface
- WIDTH, 4, operand width; dividend is 2·WIDTH bits, divisor and remainder are WIDTH bits.

- clk  input  1  rising-edge clock, single clock domain
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- n  input  2·WIDTH  dividend, captured on the accepted start edge
- d  input  WIDTH  divisor, captured on the accepted start edge
- busy  output  1  high while a division is in progress
- done  output  1  one-cycle pulse; q, r and div0 are valid from this cycle
- q  output  2·WIDTH  quotient, held until the next done
- r  output  WIDTH  remainder, held until the next done
- div0  output  1  divide-by-zero flag for the current result, held with q and r

## Operation
- FSM states: IDLE and RUN.
- IDLE, start=1:
  - Capture n and d.
  - Clear the (WIDTH+1)-bit partial remainder.
  - Load the iteration counter with 2·WIDTH.
  - Go to RUN; busy=1.
- IDLE, start=0: stay in IDLE.
- RUN, each cycle (one iteration):
  - Shift {partial remainder, dividend register} left by 1, bringing in the dividend MSB.
  - Trial-subtract d.
  - If the result is ≥ 0: keep the result and shift quotient bit 1 into the dividend register LSB.
  - Otherwise: restore the remainder and shift in 0.
  - Decrement the counter.
- RUN, counter reaches 0 on the current edge:
  - Register q (dividend register) and r (low WIDTH bits of the partial remainder).
  - div0 = 0; done = 1 for one cycle; busy = 0; return to IDLE.
- Divide by zero (d = 0 captured):
  - Result is q = all ones, r = n[WIDTH-1:0], div0 = 1.
  - Completion timing depends on the configuration (see Configuration).
- start while busy=1 is ignored, and the in-flight operands are not disturbed.
- start in the done cycle is accepted (busy=0), and that edge begins the next division.
- Outputs q, r and div0 change only on done edges or on reset.
- Arithmetic: unsigned throughout.
  - The partial remainder is WIDTH+1 bits, so the trial subtraction cannot overflow.
  - r < d is guaranteed for d ≠ 0.

## Timing
- Reset values: busy=0, done=0, q=0, r=0, div0=0, FSM=IDLE, counter=0.
- Start accepted at edge E0 gives busy=1 from E0.
- Iterations occur on edges E1..E2W.
- At E2W: done=1 and busy=0, with q, r and div0 valid. Latency from start to done is 2·WIDTH cycles (8 for WIDTH=4).
- done is high for exactly one cycle; done and busy are never both high.
- Throughput: one division per 2·WIDTH+1 cycles when start is held high continuously.
- Reset asserted mid-RUN: the next edge forces all reset values. No done is emitted, and the aborted result is discarded.
- Reset has priority over start on the same edge.

## Configuration
- DIVREM_DIV0_FAST_EN defined:
  - A divisor of 0 is detected at the start edge.
  - The FSM stays in IDLE (busy stays 0).
  - done pulses on the next edge, E1, with q = all ones, r = n[WIDTH-1:0], div0=1.
- Undefined:
  - d=0 runs the full 2·WIDTH iterations (busy high throughout).
  - The divide-by-zero values are forced at E2W.
  - done occurs at E2W, matching normal latency.
- Results and flag are identical in both builds; only latency and busy differ.

## Test plan
- WIDTH=4, n=38 (7·5+3), d=5, single start pulse → done exactly 8 cycles later, q=7, r=3, div0=0, busy low in the done cycle.
- Edge operands, WIDTH=4:
  - n=255, d=1 → q=255, r=0.
  - n=255, d=15 → q=17, r=0.
  - n=0, d=9 → q=0, r=0.
- n=0x2B, d=0 → q=0xFF, r=0xB, div0=1. done after 1 cycle with DIVREM_DIV0_FAST_EN, after 8 cycles without it.
- Start n=100, d=7, then pulse start with n=50, d=3 at cycle 3 while busy → single done with q=14, r=2. The second request is ignored, and q/r hold until the next done.
- Assert reset at cycle 4 of a run → next cycle all outputs 0 and no done pulse. A new start n=38, d=5 afterwards completes normally with q=7, r=3.
- Exhaustive, WIDTH=4, back-to-back starts (start held high): for all a, b in 1..15 and c < b, n=a·b+c → q=a, r=c, div0=0, with one done every 9 cycles.

Source files
------------

// File: rtl/div_rem.sv
// Sequential unsigned restoring divider: n (2*WIDTH bits) / d (WIDTH bits), one quotient bit per clock.
// Define DIVREM_DIV0_FAST_EN to finish divide-by-zero one cycle after start instead of after a full run.
module div_rem #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2*WIDTH-1:0] n,
  input  logic [WIDTH-1:0]   d,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] q,
  output logic [WIDTH-1:0]   r,
  output logic               div0
);

  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(W2 + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic [WIDTH:0]  rem, rem_nx, diff;
  logic [WIDTH+1:0] wide;
  logic [W2-1:0]   dvd, dvd_nx;
  logic [WIDTH-1:0] dsr, n_lo;
  logic            accept, last, borrow, skip_run;

  assign accept = (state == IDLE) && start;
  assign last   = (state == RUN) && (cnt == CW'(1));
  assign busy   = (state == RUN);

`ifdef DIVREM_DIV0_FAST_EN
  logic pend;
  assign skip_run = accept && (d == '0);
`else
  assign skip_run = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept && !skip_run) state_nx = RUN;
      RUN:  if (last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // The partial remainder stays below d, so its top bit is always zero before the shift.
  always_comb begin
    wide   = {rem, dvd[W2-1]};
    borrow = wide < {2'b00, dsr};
    diff   = wide[WIDTH:0] - {1'b0, dsr};
    rem_nx = borrow ? wide[WIDTH:0] : diff;
    dvd_nx = {dvd[W2-2:0], ~borrow};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      rem  <= '0;
      dvd  <= '0;
      dsr  <= '0;
      n_lo <= '0;
      done <= 1'b0;
      q    <= '0;
      r    <= '0;
      div0 <= 1'b0;
`ifdef DIVREM_DIV0_FAST_EN
      pend <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (accept) begin
        dvd  <= n;
        dsr  <= d;
        n_lo <= n[WIDTH-1:0];
        rem  <= '0;
        cnt  <= CW'(W2);
      end else if (state == RUN) begin
        rem <= rem_nx;
        dvd <= dvd_nx;
        cnt <= cnt - CW'(1);
      end
      if (last) begin
        done <= 1'b1;
        if (dsr == '0) begin
          q    <= '1;
          r    <= n_lo;
          div0 <= 1'b1;
        end else begin
          q    <= dvd_nx;
          r    <= rem_nx[WIDTH-1:0];
          div0 <= 1'b0;
        end
      end
`ifdef DIVREM_DIV0_FAST_EN
      // Completion one edge after a zero divisor was accepted; n_lo still holds that request.
      pend <= skip_run;
      if (pend) begin
        done <= 1'b1;
        q    <= '1;
        r    <= n_lo;
        div0 <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_div_rem.sv
// Scoreboard bench for div_rem: stimulus pushes expected results, a monitor checks each done pulse.
module tb_div_rem;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [7:0] n;
  logic [3:0] d;
  logic       busy, done, div0;
  logic [7:0] q;
  logic [3:0] r;

  typedef struct {
    logic [7:0] q;
    logic [3:0] r;
    logic       div0;
    int         start_cyc;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   vec_count = 0;
  int   miss_count = 0;

`ifdef DIVREM_DIV0_FAST_EN
  localparam int DIV0_LAT = 1;
`else
  localparam int DIV0_LAT = 8;
`endif

  div_rem #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .n(n), .d(d),
    .busy(busy), .done(done), .q(q), .r(r), .div0(div0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      checkOutput("done_busy_exclusive", {31'd0, busy}, 32'd0);
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("q", {24'd0, q}, {24'd0, e.q});
        checkOutput("r", {28'd0, r}, {28'd0, e.r});
        checkOutput("div0", {31'd0, div0}, {31'd0, e.div0});
        checkOutput("latency", cyc - e.start_cyc, e.lat);
      end
    end
  end

  // Drives one request at a negedge; the next posedge accepts it. Start is left high.
  task automatic applyStimulus(input logic [7:0] nv, input logic [3:0] dv,
                               input logic [7:0] eq, input logic [3:0] er, input logic ediv0,
                               input int lat);
    exp_t e;
    logic exp_busy;
    start = 1'b1;
    n = nv;
    d = dv;
    e.q = eq;
    e.r = er;
    e.div0 = ediv0;
    e.start_cyc = cyc + 1;
    e.lat = lat;
    sb.push_back(e);
    exp_busy = (dv != 4'd0) || (DIV0_LAT == 8);
    @(negedge clk);
    checkOutput("busy_after_start", {31'd0, busy}, {31'd0, exp_busy});
  endtask

  task automatic pulse(input logic [7:0] nv, input logic [3:0] dv,
                       input logic [7:0] eq, input logic [3:0] er, input logic ediv0, input int lat);
    applyStimulus(nv, dv, eq, er, ediv0, lat);
    start = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (sb.size() != 0) begin
      checkOutput("done_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    n = '0;
    d = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", {31'd0, busy}, 0);
    checkOutput("reset_done", {31'd0, done}, 0);
    checkOutput("reset_q", {24'd0, q}, 0);
    checkOutput("reset_r", {28'd0, r}, 0);
    checkOutput("reset_div0", {31'd0, div0}, 0);
    reset = 1'b0;
    @(negedge clk);

    pulse(8'd38, 4'd5, 8'd7, 4'd3, 1'b0, 8);
    waitDone(20);
    pulse(8'd255, 4'd1, 8'd255, 4'd0, 1'b0, 8);
    waitDone(20);
    pulse(8'd255, 4'd15, 8'd17, 4'd0, 1'b0, 8);
    waitDone(20);
    pulse(8'd0, 4'd9, 8'd0, 4'd0, 1'b0, 8);
    waitDone(20);
    pulse(8'h2B, 4'd0, 8'hFF, 4'hB, 1'b1, DIV0_LAT);
    waitDone(20);

    // A second start while busy must be ignored and results held afterwards.
    pulse(8'd100, 4'd7, 8'd14, 4'd2, 1'b0, 8);
    repeat (2) @(negedge clk);
    start = 1'b1;
    n = 8'd50;
    d = 4'd3;
    @(negedge clk);
    start = 1'b0;
    waitDone(20);
    repeat (5) @(negedge clk);
    checkOutput("hold_q", {24'd0, q}, 14);
    checkOutput("hold_r", {28'd0, r}, 2);

    // Reset in the middle of a run discards the result.
    pulse(8'd38, 4'd5, 8'd7, 4'd3, 1'b0, 8);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    checkOutput("abort_busy", {31'd0, busy}, 0);
    checkOutput("abort_done", {31'd0, done}, 0);
    checkOutput("abort_q", {24'd0, q}, 0);
    checkOutput("abort_r", {28'd0, r}, 0);
    checkOutput("abort_div0", {31'd0, div0}, 0);
    repeat (12) @(negedge clk);
    pulse(8'd38, 4'd5, 8'd7, 4'd3, 1'b0, 8);
    waitDone(20);

    // Back-to-back with start held high: one acceptance every 9 cycles.
    for (int b = 1; b <= 15; b++) begin
      for (int a = 1; a <= 15; a++) begin
        for (int c = 0; c < b; c++) begin
          applyStimulus(8'(a * b + c), 4'(b), 8'(a), 4'(c), 1'b0, 8);
          repeat (8) @(negedge clk);
        end
      end
    end
    start = 1'b0;
    waitDone(30);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
